// File: rtl/wdt_ctrl_if.sv
// Peripheral bus between the bus decoder (master) and the watchdog controller (slave).
// Handshake: master raises bus_valid with write/addr/wdata stable and holds it until
// bus_ready; slave pulses bus_ready for one cycle (read data valid only during that
// pulse); master then drops bus_valid for at least one cycle before the next access.
interface wdt_ctrl_if;
  logic        bus_valid;
  logic        bus_write;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid,
    output bus_write,
    output bus_addr,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata
  );

  modport slave (
    input  bus_valid,
    input  bus_write,
    input  bus_addr,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata
  );
endinterface

// File: rtl/wdt_ctrl.sv
// Watchdog controller: register file for the watchdog core plus a two-stage
// escalation FSM (interrupt first, then a fixed-width system reset request).
module wdt_ctrl #(
  parameter int unsigned RST_CYCLES = 16,
  parameter logic [31:0] KICK_KEY   = 32'h5A5A_5A5A
) (
  input  logic              clk,
  input  logic              rst,
  wdt_ctrl_if.slave         bus,
  output logic              wdt_en,
  output logic              wdt_live,
  output logic [31:0]       wdt_tocnt,
  input  logic              wdt_to,
  input  logic              wdt_to_write,
  output logic              irq,
  output logic              sys_rst_req,
  output logic [1:0]        dbg_state
);

  localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_ESCALATE = 2'd2,
    ST_RESET    = 2'd3
  } state_e;

  localparam logic [2:0] W_CTRL   = 3'd0;
  localparam logic [2:0] W_LOAD   = 3'd1;
  localparam logic [2:0] W_KICK   = 3'd2;
  localparam logic [2:0] W_STATUS = 3'd3;

  state_e             state_q;
  logic               wdt_en_q;
  logic               wdt_live_q;
  logic               sys_rst_q;
  logic [CNT_W-1:0]   rst_cnt_q;

  logic [3:0]         ctrl_q, ctrl_d;
  logic [31:0]        tocnt_q, tocnt_d;
  logic               irq_pend_q, irq_pend_d;
  logic               bus_ready_q, bus_ready_d;
  logic [31:0]        bus_rdata_q, bus_rdata_d;

  logic               access;
  logic               acc_wr;
  logic               acc_rd;
  logic [2:0]         word;
  logic               kick_ok;
  logic               to_ev;
  logic               set_pend;
  logic               reset_done;

  // An access is taken on the first valid cycle; the ready pulse masks the held valid.
  assign access     = bus.bus_valid & ~bus_ready_q;
  assign acc_wr     = access & bus.bus_write;
  assign acc_rd     = access & ~bus.bus_write;
  assign word       = bus.bus_addr[4:2];
  assign kick_ok    = acc_wr && (word == W_KICK) && (bus.bus_wdata == KICK_KEY);
  assign to_ev      = wdt_to_write & wdt_to;
  assign set_pend   = (state_q == ST_RUN) & ctrl_q[0] & to_ev;
  assign reset_done = (state_q == ST_RESET) && (rst_cnt_q == '0);

  always_comb begin
    ctrl_d      = ctrl_q;
    tocnt_d     = tocnt_q;
    irq_pend_d  = irq_pend_q;
    bus_ready_d = access;
    bus_rdata_d = '0;

    if (acc_wr && (word == W_CTRL) && !ctrl_q[3] && (state_q != ST_RESET)) begin
      ctrl_d = bus.bus_wdata[3:0];
    end
    // The end of the reset pulse disarms the watchdog even when LOCK is set.
    if (reset_done) begin
      ctrl_d[0] = 1'b0;
    end

    if (acc_wr && (word == W_LOAD) && !ctrl_q[3]) begin
      tocnt_d = (bus.bus_wdata == 32'd0) ? 32'd1 : bus.bus_wdata;
    end

    if (acc_wr && (word == W_STATUS) && bus.bus_wdata[1]) begin
      irq_pend_d = 1'b0;
    end
    if (set_pend) begin
      irq_pend_d = 1'b1;
    end

    if (acc_rd) begin
      case (word)
        W_CTRL:   bus_rdata_d = {28'd0, ctrl_q};
        W_LOAD:   bus_rdata_d = tocnt_q;
        W_STATUS: bus_rdata_d = {28'd0, state_q, irq_pend_q, wdt_to};
        default:  bus_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= '0;
      tocnt_q     <= 32'hFFFF_FFFF;
      irq_pend_q  <= 1'b0;
      bus_ready_q <= 1'b0;
      bus_rdata_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      tocnt_q     <= tocnt_d;
      irq_pend_q  <= irq_pend_d;
      bus_ready_q <= bus_ready_d;
      bus_rdata_q <= bus_rdata_d;
    end
  end

  // Escalation FSM; outputs are registered alongside the state so they move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_DISABLED;
      wdt_en_q   <= 1'b0;
      wdt_live_q <= 1'b0;
      sys_rst_q  <= 1'b0;
      rst_cnt_q  <= '0;
    end else begin
      wdt_live_q <= 1'b0;
      case (state_q)
        ST_DISABLED: begin
          if (ctrl_q[0]) begin
            state_q  <= ST_RUN;
            wdt_en_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!ctrl_q[0]) begin
            state_q  <= ST_DISABLED;
            wdt_en_q <= 1'b0;
          end else if (to_ev) begin
            // A kick coinciding with the timeout is dropped.
            if (ctrl_q[2]) begin
              wdt_live_q <= 1'b1;
              state_q    <= ST_ESCALATE;
            end
          end else if (kick_ok) begin
            wdt_live_q <= 1'b1;
          end
        end
        ST_ESCALATE: begin
          if (!ctrl_q[0]) begin
            state_q  <= ST_DISABLED;
            wdt_en_q <= 1'b0;
          end else if (to_ev) begin
            state_q   <= ST_RESET;
            wdt_en_q  <= 1'b0;
            sys_rst_q <= 1'b1;
            rst_cnt_q <= CNT_W'(RST_CYCLES - 1);
          end else if (kick_ok) begin
            wdt_live_q <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        ST_RESET: begin
          if (rst_cnt_q == '0) begin
            sys_rst_q <= 1'b0;
            state_q   <= ST_DISABLED;
          end else begin
            rst_cnt_q <= rst_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q  <= ST_DISABLED;
          wdt_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_ready = bus_ready_q;
  assign bus.bus_rdata = bus_rdata_q;
  assign wdt_en        = wdt_en_q;
  assign wdt_live      = wdt_live_q;
  assign wdt_tocnt     = tocnt_q;
  assign irq           = irq_pend_q & ctrl_q[1];
  assign sys_rst_req   = sys_rst_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/wdt_ctrl.md
# wdt_ctrl

Register-mapped controller that configures and sequences the watchdog timer core. It takes word accesses from the CPU peripheral bus and drives the core's enable, kick and timeout-count inputs. It watches the core's timeout outputs and escalates in two stages: first an interrupt, then, if still unserviced, a system-reset request pulse. It sits between the peripheral bus decoder and the watchdog core.

## Interface
- RST_CYCLES, 16: width in clk cycles of the sys_rst_req pulse (≥1)
- KICK_KEY, 32'h5A5A_5A5A: value that must be written to KICK to service the watchdog
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- bus_valid  input  1  access request; held by the master until bus_ready
- bus_write  input  1  1 = write, 0 = read
- bus_addr  input  5  byte address; bits [1:0] ignored
- bus_wdata  input  32  write data
- bus_ready  output  1  one-cycle response pulse
- bus_rdata  output  32  read data, valid while bus_ready=1; 0 otherwise
- wdt_en  output  1  to core WDEN
- wdt_live  output  1  to core WDLIVE; one-cycle pulse
- wdt_tocnt  output  32  to core WTOCNT
- wdt_to  input  1  core WTO level
- wdt_to_write  input  1  core WTO change strobe
- irq  output  1  level interrupt = IRQ_PEND & IRQ_EN
- sys_rst_req  output  1  system reset request pulse

## Operation
- Registers:
  - 0x00 CTRL: [0] WDEN, [1] IRQ_EN, [2] RST_EN, [3] LOCK.
  - 0x04 LOAD: 32-bit timeout count. A write of 0 stores 1.
  - 0x08 KICK: write-only; reads return 0.
  - 0x0C STATUS (read): [0] wdt_to, [1] IRQ_PEND, [3:2] state code.
  - Writing 1 to STATUS bit 1 clears IRQ_PEND.
  - Other addresses: reads return 0; writes are ignored.
- LOCK is sticky. Once set, writes to CTRL and LOAD are ignored until rst. KICK and STATUS writes remain allowed.
- A KICK write with data == KICK_KEY produces a wdt_live pulse. Any other KICK write is ignored.
- Timeout event = wdt_to_write & wdt_to (rising edge of the core timeout).
- FSM states, with STATUS code in brackets:
  - DISABLED [0]: wdt_en=0. Moves to RUN when CTRL.WDEN becomes 1.
  - RUN [1]: wdt_en=1.
    - Valid kick: wdt_live pulse.
    - Timeout event: set IRQ_PEND. If RST_EN=1, emit a wdt_live pulse (starts the second window) and go to ESCALATE. Otherwise stay in RUN.
    - WDEN cleared: go to DISABLED.
  - ESCALATE [2]: wdt_en=1.
    - Valid kick: wdt_live pulse and return to RUN. IRQ_PEND is not cleared by the kick.
    - Timeout event: go to RESET.
    - WDEN cleared: go to DISABLED.
  - RESET [3]: sys_rst_req=1 for exactly RST_CYCLES cycles, wdt_en=0. Then clear CTRL.WDEN and go to DISABLED.
    - Bus writes during RESET are accepted but have no effect on CTRL.
- Priority in the same cycle: timeout event over kick. A kick in the same cycle as a RUN timeout is dropped.
- A STATUS W1C in the same cycle as an IRQ_PEND set: the set wins.

## Timing
- Reset values:
  - bus_ready=0, bus_rdata=0, wdt_en=0, wdt_live=0, irq=0, sys_rst_req=0.
  - wdt_tocnt=32'hFFFF_FFFF.
  - CTRL=0, IRQ_PEND=0, state=DISABLED.
- rst mid-RESET terminates sys_rst_req on the next edge.
- Bus access:
  - bus_ready pulses in the cycle after the first cycle of bus_valid.
  - The register write, or read sampling, takes effect at that same edge.
  - Back-to-back accesses are spaced by at least 2 cycles (valid must drop for a cycle after ready).
- wdt_live asserts the cycle after the accepted KICK write, for 1 cycle. It also pulses on the edge after the timeout event in RUN→ESCALATE.
- wdt_en follows FSM state registered: it changes on the same edge as the state.
- wdt_tocnt updates on the edge the LOAD write is accepted.
- irq is combinational from the registered bits.
- sys_rst_req rises on the edge entering RESET.

## Test plan
- Enable/kick: write LOAD=10, CTRL=0x1, then KICK_KEY every 8 cycles for 100 cycles -> wdt_en=1, a wdt_live pulse per kick, irq=0, state=1.
- Bad key: write KICK=0x1234 -> no wdt_live pulse; the timeout event occurs at the normal count.
- IRQ-only path: CTRL=0x3, LOAD=5, no kicks -> on the timeout event IRQ_PEND=1, irq=1, state stays 1. STATUS write 0x2 -> irq=0.
- Escalation: CTRL=0x7, LOAD=5, no kicks -> first event gives irq=1 and a wdt_live pulse, state=2. Second event gives sys_rst_req=1 for 16 cycles, then state=0 and CTRL.WDEN=0.
- Rescue: the escalation case plus a valid kick in ESCALATE -> state=1, no sys_rst_req, IRQ_PEND still 1.
- Lock: CTRL=0x9, then write CTRL=0 and LOAD=3 -> readback CTRL=0x9, wdt_tocnt unchanged. After rst -> CTRL=0, wdt_tocnt=FFFF_FFFF.
